// File: rtl/ttl_decoder_pkg.sv
// Shared types and helpers for the wait-state chip-select decoder.
package ttl_decoder_pkg;

  typedef enum logic [1:0] {StIdle, StWait, StHold, StMiss} state_e;

  localparam int unsigned MaxWidthOut = 256;
  localparam int unsigned MaxWsW      = 16;
  localparam int unsigned MaxCfgW     = MaxWidthOut * MaxWsW;

  // Inactive value for the select bus; callers slice it to their width.
  localparam logic [MaxWidthOut-1:0] SelNone = '1;

  // Extract wait-state field idx from a packed configuration word.
  function automatic logic [MaxWsW-1:0] ws_field(input logic [MaxCfgW-1:0] cfg,
                                                 input int unsigned idx,
                                                 input int unsigned ws_w);
    logic [MaxWsW-1:0] mask;
    mask = (MaxWsW'(1) << ws_w) - MaxWsW'(1);
    return MaxWsW'(cfg >> (idx * ws_w)) & mask;
  endfunction

endpackage

// File: rtl/ttl_ws_counter.sv
// Loadable down-counter with a zero flag, used to time bus wait states.
module ttl_ws_counter #(
  parameter int unsigned WS_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            dec,
  input  logic [WS_W-1:0] load_val,
  output logic            zero
);

  logic [WS_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/ttl_decoder_ws.sv
// Registered chip-select decoder with per-output wait states and a ready handshake.
// Define TTL_DECODER_MISS_EN to add a miss output and complete unmapped accesses.
module ttl_decoder_ws
  import ttl_decoder_pkg::*;
#(
  parameter int unsigned WIDTH_OUT = 8,
  parameter int unsigned WIDTH_IN  = $clog2(WIDTH_OUT),
  parameter int unsigned WS_W      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable1_bar,
  input  logic                      enable2_bar,
  input  logic                      enable3,
  input  logic [WIDTH_IN-1:0]       a,
  input  logic                      req,
  input  logic [WIDTH_OUT*WS_W-1:0] ws_cfg,
  output logic [WIDTH_OUT-1:0]      y,
`ifdef TTL_DECODER_MISS_EN
  output logic                      miss,
`endif
  output logic                      ready
);

  state_e                state_q, state_d;
  logic [WIDTH_IN-1:0]   a_q, a_d;
  logic [WIDTH_OUT-1:0]  y_q, y_d;
  logic                  ready_q, ready_d;
`ifdef TTL_DECODER_MISS_EN
  logic                  miss_q, miss_d;
`endif
  logic                  hit;
  logic                  cnt_load, cnt_dec, cnt_zero;
  logic [WS_W-1:0]       ws_sel;

  assign hit    = !enable1_bar && !enable2_bar && enable3 && (32'(a) < WIDTH_OUT);
  assign ws_sel = WS_W'(ws_field(MaxCfgW'(ws_cfg), 32'(a), WS_W));

  ttl_ws_counter #(
    .WS_W(WS_W)
  ) u_ws_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .dec     (cnt_dec),
    .load_val(ws_sel),
    .zero    (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    y_d      = SelNone[WIDTH_OUT-1:0];
    ready_d  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
`ifdef TTL_DECODER_MISS_EN
    miss_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (hit) begin
            a_d      = a;
            cnt_load = 1'b1;
            y_d[a]   = 1'b0;
            state_d  = StWait;
          end else begin
            state_d = StMiss;
          end
        end
      end
      StWait: begin
        // Losing the strobe or the decode aborts before ready is ever raised.
        if (!req || !hit) begin
          state_d = StIdle;
        end else begin
          y_d[a_q] = 1'b0;
          if (cnt_zero) begin
            ready_d = 1'b1;
            state_d = StHold;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      StHold: begin
        if (!req) begin
          state_d = StIdle;
        end else begin
          y_d[a_q] = 1'b0;
          ready_d  = 1'b1;
        end
      end
      StMiss: begin
        if (!req) begin
          state_d = StIdle;
        end else begin
`ifdef TTL_DECODER_MISS_EN
          ready_d = 1'b1;
          miss_d  = 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      y_q     <= SelNone[WIDTH_OUT-1:0];
      ready_q <= 1'b0;
`ifdef TTL_DECODER_MISS_EN
      miss_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      y_q     <= y_d;
      ready_q <= ready_d;
`ifdef TTL_DECODER_MISS_EN
      miss_q  <= miss_d;
`endif
    end
  end

  assign y     = y_q;
  assign ready = ready_q;
`ifdef TTL_DECODER_MISS_EN
  assign miss  = miss_q;
`endif

endmodule

// File: tb/tb_ttl_decoder_ws.sv
// Scoreboard bench for ttl_decoder_ws: directed scenarios then random traffic vs an access model.
module tb_ttl_decoder_ws;

  localparam int unsigned WidthOut = 6;
  localparam int unsigned WidthIn  = 3;
  localparam int unsigned WsW      = 4;
`ifdef TTL_DECODER_MISS_EN
  localparam bit MissEn = 1'b1;
`else
  localparam bit MissEn = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    e1b, e2b, e3, req;
  logic [WidthIn-1:0]      a;
  logic [WidthOut*WsW-1:0] ws_cfg;
  logic [WidthOut-1:0]     y;
  logic                    ready;
`ifdef TTL_DECODER_MISS_EN
  logic                    miss;
`endif

  typedef struct packed {
    logic [WidthOut-1:0] y;
    logic                ready;
    logic                miss;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Access-level model: an access starts on a sampled req, targets one output (or none),
  // and completes once the programmed number of wait cycles has elapsed.
  bit m_busy = 0;
  int m_tgt, m_wait, m_elapsed;

  ttl_decoder_ws #(
    .WIDTH_OUT(WidthOut),
    .WIDTH_IN (WidthIn),
    .WS_W     (WsW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable1_bar(e1b),
    .enable2_bar(e2b),
    .enable3    (e3),
    .a          (a),
    .req        (req),
    .ws_cfg     (ws_cfg),
    .y          (y),
`ifdef TTL_DECODER_MISS_EN
    .miss       (miss),
`endif
    .ready      (ready)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    exp_t e;
    bit   hit_now;
    hit_now = !e1b && !e2b && e3 && (int'(a) < int'(WidthOut));
    e.y     = '1;
    e.ready = 1'b0;
    e.miss  = 1'b0;
    if (rst) begin
      m_busy = 0;
    end else if (!m_busy) begin
      if (req) begin
        m_busy    = 1;
        m_elapsed = 0;
        m_tgt     = hit_now ? int'(a) : -1;
        m_wait    = hit_now ? int'((ws_cfg >> (int'(a) * WsW)) & 24'hF) : 0;
      end
    end else if (!req) begin
      m_busy = 0;
    end else if (m_tgt >= 0 && m_elapsed <= m_wait && !hit_now) begin
      m_busy = 0;
    end else begin
      m_elapsed++;
    end
    if (m_busy) begin
      if (m_tgt >= 0) begin
        e.y[m_tgt] = 1'b0;
        e.ready    = (m_elapsed > m_wait);
      end else begin
        e.ready = MissEn && (m_elapsed >= 1);
        e.miss  = e.ready;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req_v);
    end
  endtask

  // Monitor: outputs are presented every cycle, so pop one expectation per falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("y", 32'(y), 32'(e.y));
        check("ready", 32'(ready), 32'(e.ready));
`ifdef TTL_DECODER_MISS_EN
        check("miss", 32'(miss), 32'(e.miss));
`endif
      end
    end
  end

  function automatic logic [WidthOut*WsW-1:0] cfg_one(input int idx, input int val);
    logic [WidthOut*WsW-1:0] c;
    c = '0;
    c[idx*WsW +: WsW] = WsW'(val);
    return c;
  endfunction

  initial begin
    rst = 1'b1; e1b = 1'b0; e2b = 1'b0; e3 = 1'b1; req = 1'b0; a = '0; ws_cfg = '0;
    #1;
    step(2);
    rst = 1'b0;
    step(1);

    // Reset in the middle of a completed access, then restart with req still high.
    ws_cfg = cfg_one(3, 2); a = 3'd3; req = 1'b1;
    step(5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(5);
    req = 1'b0;
    step(2);

    // Zero wait states.
    ws_cfg = '0; a = 3'd5; req = 1'b1;
    step(3);
    req = 1'b0;
    step(2);

    // Three wait states; address change to another mapped output is ignored.
    ws_cfg = cfg_one(1, 3); a = 3'd1; req = 1'b1;
    step(1);
    a = 3'd4;
    step(6);
    req = 1'b0;
    step(2);

    // Abort by dropping an enable during the wait.
    ws_cfg = cfg_one(0, 5); a = 3'd0; req = 1'b1;
    step(2);
    e2b = 1'b1;
    step(3);
    e2b = 1'b0; req = 1'b0;
    step(2);

    // Unmapped address held for 20+ cycles.
    a = 3'd7; req = 1'b1;
    step(21);
    req = 1'b0;
    step(2);

    // Back-to-back: req held after completion, then one low cycle and a new access.
    ws_cfg = cfg_one(2, 2); a = 3'd2; req = 1'b1;
    step(8);
    req = 1'b0;
    step(1);
    req = 1'b1;
    step(6);
    req = 1'b0;
    step(2);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) ws_cfg = (WidthOut*WsW)'($urandom);
      if ($urandom_range(0, 3) == 0) a = WidthIn'($urandom);
      e1b = ($urandom_range(0, 15) == 0);
      e2b = ($urandom_range(0, 15) == 0);
      e3  = ($urandom_range(0, 15) != 0);
      if (req) req = ($urandom_range(0, 11) != 0);
      else     req = ($urandom_range(0, 2) == 0);
      step(1);
    end
    rst = 1'b0; req = 1'b0;
    step(2);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
